// File: rtl/modexp_lr_ctrl.sv
// Left-to-right Montgomery modular-exponentiation controller driving an external MM unit.
// Optional constant-time mode: define MODEXP_CONST_TIME_EN.
module modexp_lr_ctrl #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = $clog2(WIDTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  in_x_i,
  input  logic [WIDTH-1:0]  in_e_i,
  input  logic [ELEN_W-1:0] in_e_len_i,
  input  logic [WIDTH-1:0]  in_rm_i,
  input  logic [WIDTH-1:0]  in_r2m_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  result_o,
  output logic              mm_start_o,
  output logic [WIDTH:0]    mm_a_o,
  output logic [WIDTH:0]    mm_b_o,
  input  logic [WIDTH:0]    mm_result_i,
  input  logic              mm_done_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_XT_S, S_XT_W, S_SQ_S, S_SQ_W,
    S_MU_S, S_MU_W, S_OUT_S, S_OUT_W, S_DONE
  } state_t;

`ifdef MODEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(WIDTH);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [WIDTH-1:0]    e_q, e_d;
  logic [ELEN_W-1:0]   elen_q, elen_d;
  logic [ELEN_W-1:0]   i_q, i_d;
  logic [WIDTH:0]      a_q, a_d;
  logic [WIDTH:0]      xt_q, xt_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH:0]      mm_a_q, mm_a_d;
  logic [WIDTH:0]      mm_b_q, mm_b_d;
  logic                mm_start_q, mm_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ELEN_W-1:0]   elen_clamp;
  logic                e_bit;
  logic                last_bit;
`ifdef MODEXP_CONST_TIME_EN
  logic [WIDTH:0]      dummy_q, dummy_d;
`endif

  assign elen_clamp = (in_e_len_i > ELEN_MAX) ? ELEN_MAX : in_e_len_i;
  assign last_bit   = (i_q == '0);

  // Plain mux on the bit index keeps the select width independent of WIDTH.
  always_comb begin
    e_bit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_q == ELEN_W'(k)) e_bit = e_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    e_d      = e_q;
    elen_d   = elen_q;
    i_d      = i_q;
    a_d      = a_q;
    xt_d     = xt_q;
    result_d = result_q;
`ifdef MODEXP_CONST_TIME_EN
    dummy_d  = dummy_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = in_x_i;
          e_d     = in_e_i;
          elen_d  = elen_clamp;
          a_d     = {1'b0, in_rm_i};
          xt_d    = {1'b0, in_r2m_i};
          state_d = S_XT_S;
        end
      end
      S_XT_S: state_d = S_XT_W;
      S_XT_W: begin
        if (mm_done_i) begin
          xt_d = mm_result_i;
          if (elen_q != '0) begin
            i_d     = elen_q - ELEN_W'(1);
            state_d = S_SQ_S;
          end else begin
            state_d = S_OUT_S;
          end
        end
      end
      S_SQ_S: state_d = S_SQ_W;
      S_SQ_W: begin
        if (mm_done_i) begin
          a_d = mm_result_i;
          if (e_bit || CONST_TIME) begin
            state_d = S_MU_S;
          end else if (last_bit) begin
            state_d = S_OUT_S;
          end else begin
            i_d     = i_q - ELEN_W'(1);
            state_d = S_SQ_S;
          end
        end
      end
      S_MU_S: state_d = S_MU_W;
      S_MU_W: begin
        if (mm_done_i) begin
`ifdef MODEXP_CONST_TIME_EN
          // Zero bits still multiply; the product lands in the dummy so timing is flat.
          if (e_bit) a_d = mm_result_i;
          else       dummy_d = mm_result_i;
`else
          a_d = mm_result_i;
`endif
          if (last_bit) begin
            state_d = S_OUT_S;
          end else begin
            i_d     = i_q - ELEN_W'(1);
            state_d = S_SQ_S;
          end
        end
      end
      S_OUT_S: state_d = S_OUT_W;
      S_OUT_W: begin
        if (mm_done_i) begin
          a_d      = mm_result_i;
          result_d = mm_result_i[WIDTH-1:0];
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are loaded on entry to a start state and held through the wait state.
  always_comb begin
    mm_a_d = mm_a_q;
    mm_b_d = mm_b_q;
    case (state_d)
      S_XT_S: begin
        mm_a_d = {1'b0, x_d};
        mm_b_d = xt_d;
      end
      S_SQ_S: begin
        mm_a_d = a_d;
        mm_b_d = a_d;
      end
      S_MU_S: begin
        mm_a_d = a_d;
        mm_b_d = xt_d;
      end
      S_OUT_S: begin
        mm_a_d = a_d;
        mm_b_d = (WIDTH+1)'(1);
      end
      default: ;
    endcase
  end

  assign mm_start_d = (state_d == S_XT_S) || (state_d == S_SQ_S) ||
                      (state_d == S_MU_S) || (state_d == S_OUT_S);
  assign busy_d     = (state_d != S_IDLE);
  assign done_d     = (state_d == S_DONE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      e_q        <= '0;
      elen_q     <= '0;
      i_q        <= '0;
      a_q        <= '0;
      xt_q       <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
      dummy_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      elen_q     <= elen_d;
      i_q        <= i_d;
      a_q        <= a_d;
      xt_q       <= xt_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MODEXP_CONST_TIME_EN
      dummy_q    <= dummy_d;
`endif
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign mm_start_o = mm_start_q;
  assign mm_a_o     = mm_a_q;
  assign mm_b_o     = mm_b_q;

endmodule

// File: tb/tb_modexp_lr_ctrl.sv
// Directed bench for modexp_lr_ctrl: WIDTH=8, M=13, RM=9, R2M=3, MM latency D=3.
module tb_modexp_lr_ctrl;

  localparam int W  = 8;
  localparam int EW = 4;
  localparam int D  = 3;
`ifdef MODEXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_x, in_e, in_rm, in_r2m;
  logic [EW-1:0] in_e_len;
  logic          busy, done, mm_start, mm_done;
  logic [W-1:0]  result;
  logic [W:0]    mm_a, mm_b, mm_result;
  logic          model_done, spur_done;
  logic [W:0]    model_result;

  int n_assert = 0;
  int n_fail   = 0;
  int mm_calls = 0;

  assign mm_done   = model_done | spur_done;
  assign mm_result = spur_done ? 9'h1AA : model_result;

  always #5 clk = ~clk;

  modexp_lr_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_x_i(in_x), .in_e_i(in_e), .in_e_len_i(in_e_len),
    .in_rm_i(in_rm), .in_r2m_i(in_r2m),
    .busy_o(busy), .done_o(done), .result_o(result),
    .mm_start_o(mm_start), .mm_a_o(mm_a), .mm_b_o(mm_b),
    .mm_result_i(mm_result), .mm_done_i(mm_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Montgomery product for M=13, R=256: R^-1 mod 13 = 3.
  function automatic logic [W:0] mm_f(input logic [W:0] a, input logic [W:0] b);
    int p;
    p = (int'(a) * int'(b) * 3) % 13;
    return (W+1)'(p);
  endfunction

  initial begin
    logic [W:0] ca, cb;
    model_done   = 1'b0;
    model_result = '0;
    forever begin
      @(posedge clk); #1;
      while (mm_start) begin
        ca = mm_a;
        cb = mm_b;
        mm_calls++;
        repeat (D) @(posedge clk);
        #1;
        if (busy) check("mm operands stable", {23'd0, mm_a, mm_b} ^ {23'd0, ca, cb}, 32'd0);
        model_result = mm_f(ca, cb);
        model_done   = 1'b1;
        @(posedge clk); #1;
        model_done   = 1'b0;
      end
    end
  end

  // Called at #1 after an edge; leaves the bench one cycle after DONE.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] e,
                        input logic [EW-1:0] elen, input logic [W-1:0] exp_res,
                        input int n_def, input int n_ct, input bit inject);
    int n, cyc, calls0;
    n = CT ? n_ct : n_def;
    in_x = x; in_e = e; in_e_len = elen; in_rm = 8'd9; in_r2m = 8'd3;
    calls0 = mm_calls;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_x = 8'd7; in_e = 8'hFF; in_e_len = 4'd8; in_rm = 8'd0; in_r2m = 8'd0;
    cyc = 1;
    while (!done && cyc < 600) begin
      start = inject && (cyc == 3 || cyc == 7);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " done cycle"}, cyc, 1 + n * (D + 1));
    check({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, " mm count"}, mm_calls - calls0, n);
    @(posedge clk); #1;
    check({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; spur_done = 1'b0;
    in_x = '0; in_e = '0; in_e_len = '0; in_rm = 8'd9; in_r2m = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset mm_start", {31'd0, mm_start}, 32'd0);
    check("reset result", {24'd0, result}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("x2e5", 8'd2, 8'd5, 4'd3, 8'd6, 7, 8, 1'b0);
    run_op("x2e5 start-while-busy", 8'd2, 8'd5, 4'd3, 8'd6, 7, 8, 1'b1);

    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(posedge clk); #1;
    check("spurious mm_done A", {23'd0, dut.a_q}, 32'd6);
    check("spurious mm_done result", {24'd0, result}, 32'd6);
    check("spurious mm_done busy", {30'd0, busy, done}, 32'd0);

    run_op("x3e15", 8'd3, 8'd15, 4'd4, 8'd1, 10, 10, 1'b0);
    run_op("elen0", 8'd7, 8'hFF, 4'd0, 8'd1, 2, 2, 1'b0);
    run_op("x2e7", 8'd2, 8'd7, 4'd3, 8'd11, 8, 8, 1'b0);
    run_op("elen clamp", 8'd2, 8'd5, 4'd15, 8'd6, 12, 18, 1'b0);

    in_x = 8'd2; in_e = 8'd5; in_e_len = 4'd3; in_rm = 8'd9; in_r2m = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("busy before abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort state", {28'd0, dut.state_q}, 32'd0);
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort result", {24'd0, result}, 32'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no activity after abort", {31'd0, saw_done}, 32'd0);

    run_op("x3e5 after reset", 8'd3, 8'd5, 4'd3, 8'd9, 7, 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
